shift_ctrl: RTL and testbench

Registered front-end for the 8-bit shift/rotate unit (`przes_obr`). Accepts shift commands over a valid/ready handshake, normalises the shift amount, and drives the combinational shifter's control inputs from a registered issue stage. Captures the shifter result together with carry and zero flags into an output register with backpressure. Sustains one command per cycle.

---
 rtl/shift_ctrl_if.sv | 24 ++
 rtl/shift_ctrl.sv | 157 +++++++++++++++
 tb/tb_shift_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/shift_ctrl_if.sv
// rtl/shift_ctrl_if.sv - command and result handshake bundle for shift_ctrl
interface shift_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_amt;
    logic [2:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_carry;
    logic       out_zero;
    logic       out_err;

    modport slave (
        input  in_valid, in_data, in_amt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero, out_err
    );

    modport master (
        output in_valid, in_data, in_amt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero, out_err
    );
endinterface

// File: rtl/shift_ctrl.sv
// rtl/shift_ctrl.sv - registered issue/output front-end for the 8-bit shift/rotate unit
module shift_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    shift_ctrl_if.slave      bus,
    output logic [7:0]       sh_i,
    output logic [3:0]       sh_n,
    output logic             sh_lr,
    output logic             sh_ar,
    output logic             sh_rot,
    input  logic [7:0]       sh_o,
    output logic [CNT_W-1:0] op_count
);
    localparam logic [2:0] OP_LSR = 3'd0;
    localparam logic [2:0] OP_LSL = 3'd1;
    localparam logic [2:0] OP_ASR = 3'd2;
    localparam logic [2:0] OP_ASL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;
    localparam logic [2:0] OP_ROL = 3'd5;

    logic             a_valid_q, a_valid_d;
    logic [7:0]       a_data_q, a_data_d;
    logic [3:0]       a_n_q, a_n_d;
    logic [2:0]       a_op_q, a_op_d;
    logic             a_carry_q, a_carry_d;
    logic             b_valid_q, b_valid_d;
    logic [7:0]       b_data_q, b_data_d;
    logic             b_carry_q, b_carry_d;
    logic             b_zero_q, b_zero_d;
    logic             b_err_q, b_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       accept;
    logic       b_load;
    logic       a_legal;
    logic [3:0] n_in;
    logic       carry_in;
    logic [7:0] r_tap;
    logic [7:0] l_tap;
    logic [7:0] res_data;
    logic       res_carry;

    assign b_load       = a_valid_q && (!b_valid_q || bus.out_ready);
    assign bus.in_ready = !a_valid_q || b_load;
    assign accept       = bus.in_valid && bus.in_ready;

    // Amount normalisation and shift carry are resolved at accept, where in_amt is still visible.
    always_comb begin
        n_in     = 4'd0;
        carry_in = 1'b0;
        case (bus.in_op)
            OP_LSR, OP_LSL, OP_ASR, OP_ASL: n_in = (bus.in_amt > 4'd8) ? 4'd8 : bus.in_amt;
            OP_ROR, OP_ROL:                 n_in = {1'b0, bus.in_amt[2:0]};
            default:                        n_in = 4'd0;
        endcase
        r_tap = bus.in_data >> (n_in - 4'd1);
        l_tap = bus.in_data >> (4'd8 - n_in);
        if (n_in != 4'd0) begin
            case (bus.in_op)
                OP_LSR:         carry_in = (bus.in_amt <= 4'd8) && r_tap[0];
                OP_ASR:         carry_in = r_tap[0];
                OP_LSL, OP_ASL: carry_in = (bus.in_amt <= 4'd8) && l_tap[0];
                default:        carry_in = 1'b0;
            endcase
        end
    end

    assign sh_i   = a_data_q;
    assign sh_n   = a_n_q;
    assign sh_lr  = (a_op_q == OP_LSL) || (a_op_q == OP_ASL) || (a_op_q == OP_ROL);
    assign sh_ar  = (a_op_q == OP_ASR);
    assign sh_rot = (a_op_q == OP_ROR) || (a_op_q == OP_ROL);

    // Rotate carry depends on the shifter result, so it is resolved when B loads.
    always_comb begin
        a_legal   = (a_op_q < 3'd6);
        res_data  = a_legal ? sh_o : a_data_q;
        res_carry = 1'b0;
        if (a_legal) begin
            if (sh_rot)
                res_carry = (a_n_q != 4'd0) && ((a_op_q == OP_ROR) ? sh_o[7] : sh_o[0]);
            else
                res_carry = a_carry_q;
        end
    end

    always_comb begin
        a_valid_d = a_valid_q;
        a_data_d  = a_data_q;
        a_n_d     = a_n_q;
        a_op_d    = a_op_q;
        a_carry_d = a_carry_q;
        b_valid_d = b_valid_q;
        b_data_d  = b_data_q;
        b_carry_d = b_carry_q;
        b_zero_d  = b_zero_q;
        b_err_d   = b_err_q;
        cnt_d     = cnt_q;
        if (accept) begin
            a_valid_d = 1'b1;
            a_data_d  = bus.in_data;
            a_n_d     = n_in;
            a_op_d    = bus.in_op;
            a_carry_d = carry_in;
        end else if (b_load) begin
            a_valid_d = 1'b0;
        end
        if (b_load) begin
            b_valid_d = 1'b1;
            b_data_d  = res_data;
            b_carry_d = res_carry;
            b_zero_d  = (res_data == 8'd0);
            b_err_d   = !a_legal;
        end else if (bus.out_ready) begin
            b_valid_d = 1'b0;
        end
        if (b_valid_q && bus.out_ready)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            a_data_q  <= 8'd0;
            a_n_q     <= 4'd0;
            a_op_q    <= 3'd0;
            a_carry_q <= 1'b0;
            b_valid_q <= 1'b0;
            b_data_q  <= 8'd0;
            b_carry_q <= 1'b0;
            b_zero_q  <= 1'b0;
            b_err_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            a_valid_q <= a_valid_d;
            a_data_q  <= a_data_d;
            a_n_q     <= a_n_d;
            a_op_q    <= a_op_d;
            a_carry_q <= a_carry_d;
            b_valid_q <= b_valid_d;
            b_data_q  <= b_data_d;
            b_carry_q <= b_carry_d;
            b_zero_q  <= b_zero_d;
            b_err_q   <= b_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.out_valid = b_valid_q;
    assign bus.out_data  = b_data_q;
    assign bus.out_carry = b_carry_q;
    assign bus.out_zero  = b_zero_q;
    assign bus.out_err   = b_err_q;
    assign op_count      = cnt_q;
endmodule

// File: tb/tb_shift_ctrl.sv
// tb/tb_shift_ctrl.sv - directed self-checking bench for shift_ctrl with a behavioural shifter
module tb_shift_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sh_i;
    logic [3:0]  sh_n;
    logic        sh_lr, sh_ar, sh_rot;
    logic [7:0]  sh_o;
    logic [15:0] op_count;
    int          total = 0;
    int          bad = 0;

    shift_ctrl_if bus();

    shift_ctrl #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sh_i     (sh_i),
        .sh_n     (sh_n),
        .sh_lr    (sh_lr),
        .sh_ar    (sh_ar),
        .sh_rot   (sh_rot),
        .sh_o     (sh_o),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] shifter(logic [7:0] i, logic [3:0] n, logic lr, logic ar, logic rot);
        logic [15:0]       w;
        logic signed [7:0] s;
        w = {i, i};
        s = i;
        if (rot) begin
            if (lr) begin
                w = w << n;
                return w[15:8];
            end
            w = w >> n;
            return w[7:0];
        end
        if (lr) return i << n;
        if (ar) return s >>> n;
        return i >> n;
    endfunction

    assign sh_o = shifter(sh_i, sh_n, sh_lr, sh_ar, sh_rot);

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One isolated command through an empty pipe with out_ready held high.
    task automatic run_cmd(string tag, logic [2:0] op, logic [7:0] d, logic [3:0] amt,
                           logic [3:0] xn, logic [2:0] xctl,
                           logic [7:0] xd, logic xc, logic xz, logic xe);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_data   = d;
        bus.in_amt    = amt;
        bus.out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_sh_n"}, 32'(sh_n), 32'(xn));
        chk({tag, "_sh_ctl"}, 32'({sh_lr, sh_ar, sh_rot}), 32'(xctl));
        chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.out_data), 32'(xd));
        chk({tag, "_carry"}, 32'(bus.out_carry), 32'(xc));
        chk({tag, "_zero"}, 32'(bus.out_zero), 32'(xz));
        chk({tag, "_err"}, 32'(bus.out_err), 32'(xe));
        step();
        chk({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  sd [10];
        logic [15:0] pat;
        int          tx;
        int          rx;

        sd  = '{8'h01, 8'h02, 8'h35, 8'hFF, 8'h80, 8'h00, 8'hA5, 8'h3C, 8'h7E, 8'h11};
        pat = 16'b1011_0110_0101_1101;

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus.in_amt    = 4'd0;
        bus.in_op     = 3'd0;
        bus.out_ready = 1'b0;

        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_flags", 32'({bus.out_carry, bus.out_zero, bus.out_err}), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_sh", 32'({sh_i, sh_n, sh_lr, sh_ar, sh_rot}), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        step();

        //       tag       op    data   amt    n     ctl     data   c     z     e
        run_cmd("asr3",   3'd2, 8'h90, 4'd3,  4'd3, 3'b010, 8'hF2, 1'b0, 1'b0, 1'b0);
        run_cmd("lsl1",   3'd1, 8'h81, 4'd1,  4'd1, 3'b100, 8'h02, 1'b1, 1'b0, 1'b0);
        run_cmd("lsr12",  3'd0, 8'hFF, 4'd12, 4'd8, 3'b000, 8'h00, 1'b0, 1'b1, 1'b0);
        run_cmd("asr12",  3'd2, 8'h80, 4'd12, 4'd8, 3'b010, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_cmd("ror9",   3'd4, 8'h01, 4'd9,  4'd1, 3'b001, 8'h80, 1'b1, 1'b0, 1'b0);
        run_cmd("rol8",   3'd5, 8'h80, 4'd8,  4'd0, 3'b101, 8'h80, 1'b0, 1'b0, 1'b0);
        run_cmd("ill6",   3'd6, 8'h5A, 4'd3,  4'd0, 3'b000, 8'h5A, 1'b0, 1'b0, 1'b1);
        run_cmd("asl2",   3'd3, 8'h4F, 4'd2,  4'd2, 3'b100, 8'h3C, 1'b1, 1'b0, 1'b0);
        run_cmd("lsr8",   3'd0, 8'h80, 4'd8,  4'd8, 3'b000, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("count9", 32'(op_count), 32'd9);

        // Backpressure: fill B then A, hold, then reset mid-stream.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op     = 3'd1;
        bus.in_amt    = 4'd1;
        bus.in_data   = 8'h01;
        step();
        bus.in_data = 8'h03;
        #1;
        chk("bp_a_accept", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_data = 8'h07;
        #1;
        chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_data", 32'(bus.out_data), 32'h02);
        step();
        chk("bp_hold_data", 32'(bus.out_data), 32'h02);
        chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_count", 32'(op_count), 32'd0);
        bus.in_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
        step();

        // Stream of ROR-by-1 commands under a fixed irregular out_ready pattern.
        tx = 0;
        rx = 0;
        bus.in_op  = 3'd4;
        bus.in_amt = 4'd1;
        for (int cyc = 0; cyc < 300 && rx < 10; cyc++) begin
            bus.out_ready = pat[cyc % 16];
            bus.in_valid  = (tx < 10);
            bus.in_data   = sd[tx % 10];
            #1;
            if (bus.out_valid && bus.out_ready) begin
                chk("stream_data", 32'(bus.out_data), 32'({sd[rx][0], sd[rx][7:1]}));
                chk("stream_carry", 32'(bus.out_carry), 32'(sd[rx][0]));
                rx++;
            end
            if (bus.in_valid && bus.in_ready)
                tx++;
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stream_rx", 32'(rx), 32'd10);
        step();
        step();
        chk("stream_empty", 32'(bus.out_valid), 32'd0);
        chk("stream_count", 32'(op_count), 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
